sa_output_deskew: RTL and testbench

SA_OUTPUT_DESKEW -- requirements
Module: sa_output_deskew

---
 rtl/sa_output_deskew_pkg.sv | 18 +
 rtl/sa_deskew_fifo.sv | 74 +++++++
 rtl/sa_output_deskew.sv | 104 ++++++++++
 tb/tb_sa_output_deskew.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_output_deskew_pkg.sv
// Shared constants, occupancy-state encoding and pointer sizing for the
// systolic-array output de-skew block.
package sa_output_deskew_pkg;

  localparam int PSUM_W = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_FULL   = 2'd2
  } occ_state_e;

  // One extra bit beyond the address so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sa_deskew_fifo.sv
// Synchronous result FIFO carrying a tile-last bit alongside each vector.
// Accepts a push when full only if the head is popped on the same edge.
module sa_deskew_fifo
  import sa_output_deskew_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic             accept_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ_d;
  logic [WIDTH:0] mem_q [DEPTH];
  occ_state_e     state_q;
  logic           full;
  logic           pop;
  logic           accept;

  assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o  = (state_q != OCC_EMPTY);
  assign pop      = valid_o && ready_i;
  assign accept   = push_i && (!full || pop);
  assign accept_o = accept;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, accept};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    occ_d    = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= OCC_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        OCC_EMPTY:  if (accept) state_q <= OCC_ACTIVE;
        OCC_ACTIVE: begin
          if (occ_d == DEPTH_P)  state_q <= OCC_FULL;
          else if (occ_d == '0)  state_q <= OCC_EMPTY;
        end
        OCC_FULL:   if (pop && !accept) state_q <= OCC_ACTIVE;
        default:    state_q <= OCC_EMPTY;
      endcase
    end
  end

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= {last_i, data_i};
  end

  assign {last_o, data_o} = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

endmodule

// File: rtl/sa_output_deskew.sv
// Re-aligns skewed systolic-array column outputs and buffers whole vectors,
// tagging tile boundaries. Define SA_DESKEW_OVERFLOW_EN for a sticky drop flag.
module sa_output_deskew
  import sa_output_deskew_pkg::*;
#(
  parameter int COL        = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_LEN   = 9
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic [COL*PSUM_W-1:0] in_south,
  input  logic                  in_valid,
  output logic [COL*PSUM_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_overflow
);

  localparam int TW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  localparam logic [TW-1:0] TILE_MAX = TW'(TILE_LEN - 1);

  logic [COL*PSUM_W-1:0] aligned;
  logic                  aligned_vld;
  logic [TW-1:0]         tile_q, tile_d;
  logic                  push_last;
  logic                  push_ok;

  // De-skew: column c waits COL-1-c cycles for the last column to catch up.
  for (genvar c = 0; c < COL; c++) begin : g_col
    localparam int D = COL - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*PSUM_W +: PSUM_W] = in_south[c*PSUM_W +: PSUM_W];
    end else begin : g_dly
      logic [PSUM_W-1:0] stg_q [D];
      always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
          for (int i = 0; i < D; i++) stg_q[i] <= '0;
        end else begin
          stg_q[0] <= in_south[c*PSUM_W +: PSUM_W];
          for (int i = 1; i < D; i++) stg_q[i] <= stg_q[i-1];
        end
      end
      assign aligned[c*PSUM_W +: PSUM_W] = stg_q[D-1];
    end
  end

  if (COL == 1) begin : g_vld_pass
    assign aligned_vld = in_valid;
  end else begin : g_vld_dly
    logic [COL-2:0] vld_q;
    always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int i = 1; i <= COL - 2; i++) vld_q[i] <= vld_q[i-1];
      end
    end
    assign aligned_vld = vld_q[COL-2];
  end

  // Tile position advances only on vectors the FIFO actually took.
  assign push_last = (tile_q == TILE_MAX);

  always_comb begin
    tile_d = tile_q;
    if (push_ok) tile_d = push_last ? '0 : tile_q + 1'b1;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) tile_q <= '0;
    else        tile_q <= tile_d;
  end

  sa_deskew_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COL*PSUM_W)
  ) u_fifo (
    .clk_i    (in_clk),
    .rst_i    (in_rst),
    .push_i   (aligned_vld),
    .data_i   (aligned),
    .last_i   (push_last),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .data_o   (out_data),
    .last_o   (out_last),
    .accept_o (push_ok)
  );

`ifdef SA_DESKEW_OVERFLOW_EN
  logic ovf_q;
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)                         ovf_q <= 1'b0;
    else if (aligned_vld && !push_ok)   ovf_q <= 1'b1;
  end
  assign out_overflow = ovf_q;
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sa_output_deskew.sv
// Directed bench for sa_output_deskew: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_sa_output_deskew;

  localparam int C = 4;
  localparam int D = 4;
  localparam int T = 3;
`ifdef SA_DESKEW_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_south;
  logic         in_valid;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_overflow;

  logic [31:0]  d1_south;
  logic         d1_valid;
  logic [31:0]  d1_data;
  logic         d1_ovalid;
  logic         d1_ready;
  logic         d1_last;
  logic         d1_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sa_output_deskew #(.COL(C), .FIFO_DEPTH(D), .TILE_LEN(T)) dut (
    .in_clk(clk), .in_rst(rst), .in_south(in_south), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_overflow(out_overflow)
  );

  sa_output_deskew #(.COL(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_south(d1_south), .in_valid(d1_valid),
    .out_data(d1_data), .out_valid(d1_ovalid), .out_ready(d1_ready),
    .out_last(d1_last), .out_overflow(d1_ovf)
  );

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a vector issued after edge e is offered to the buffer at edge e+C.
  logic [128:0] mq[$];
  logic [127:0] arr[int];
  logic [127:0] hist[int];
  int           m_tile = 0;
  bit           m_ovf = 1'b0;
  int           e_cnt = 0;

  always @(posedge clk) begin
    bit pop;
    bit was_full;
    e_cnt++;
    if (rst) begin
      mq.delete();
      m_tile = 0;
      m_ovf  = 1'b0;
    end else begin
      pop      = (mq.size() != 0) && out_ready;
      was_full = (mq.size() == D);
      if (pop) void'(mq.pop_front());
      if (arr.exists(e_cnt)) begin
        if (!was_full || pop) begin
          mq.push_back({(m_tile == T - 1), arr[e_cnt]});
          m_tile = (m_tile + 1) % T;
        end else begin
          m_ovf = 1'b1;
        end
        arr.delete(e_cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ovf", out_overflow, 0);
    end else begin
      chk("m_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_data", out_data, mq[0][127:0]);
        chk("m_last", out_last, mq[0][128]);
      end
      chk("m_ovf", out_overflow, OVF_EN && m_ovf);
    end
  end

  function automatic logic [127:0] mk(input logic [31:0] id);
    return {id + 32'h3000, id + 32'h2000, id + 32'h1000, id};
  endfunction

  // Drives one cycle: column c carries the vector issued c cycles earlier.
  task automatic step(input bit iss, input logic [127:0] v, input bit rdy);
    @(posedge clk);
    #1;
    if (iss) begin
      hist[e_cnt]     = v;
      arr[e_cnt + C]  = v;
    end
    for (int c = 0; c < C; c++)
      in_south[c*32 +: 32] = hist.exists(e_cnt - c) ? hist[e_cnt - c][c*32 +: 32] : 32'h0;
    in_valid  = iss;
    out_ready = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    arr.delete();
    hist.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_south  = '0;
    #1;
    chk("rst_imm_valid", out_valid, 0);
    chk("rst_imm_data", out_data, 0);
    chk("rst_imm_ovf", out_overflow, 0);
    chk("rst_imm_d1_valid", d1_ovalid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] lastpat;
    int         n;
    rst       = 1'b1;
    in_south  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d1_south  = '0;
    d1_valid  = 1'b0;
    d1_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", out_valid, 0);
    chk("init_d1_valid", d1_ovalid, 0);
    rst = 1'b0;

    // Scenario 1: skewed columns recombine into one vector, latency C.
    step(1'b1, 128'h00000044_00000033_00000022_00000011, 1'b0);
    idle(3, 1'b0);
    chk("s1_not_yet", out_valid, 0);
    idle(1, 1'b0);
    chk("s1_valid", out_valid, 1);
    chk("s1_data", out_data, 128'h00000044_00000033_00000022_00000011);
    chk("s1_last", out_last, 0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("s1_drained", out_valid, 0);

    // Scenario 2: tile boundaries on vectors 3 and 6.
    do_reset();
    lastpat = '0;
    n = 0;
    for (int i = 0; i < 13; i++) begin
      step(i < 7, mk(32'h10 + i), 1'b1);
      if (out_valid) begin
        if (n < 7) begin
          lastpat[n] = out_last;
          chk("s2_order", out_data[31:0], 32'h10 + n);
        end
        n++;
      end
    end
    chk("s2_count", n, 7);
    chk("s2_lastpat", lastpat, 7'b0100100);

    // Scenario 3: stalled consumer, fifth vector dropped.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, mk(32'h100 + i), 1'b0);
    idle(5, 1'b0);
    chk("s3_ovf", out_overflow, OVF_EN ? 1 : 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1);
      chk("s3_head", out_data[31:0], 32'h100 + k);
      chk("s3_last", out_last, k == 2);
    end
    idle(1, 1'b0);
    chk("s3_empty", out_valid, 0);

    // Scenario 4: push and pop on the same edge while full.
    do_reset();
    chk("s4_ovf_cleared", out_overflow, 0);
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'h200 + i), 1'b0);
    idle(4, 1'b0);
    step(1'b1, mk(32'h204), 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("s4_ovf", out_overflow, 0);
    chk("s4_valid", out_valid, 1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, '0, 1'b1);
      chk("s4_head", out_data[31:0], 32'h200 + k);
      chk("s4_last", out_last, k == 2);
    end
    idle(1, 1'b0);
    chk("s4_empty", out_valid, 0);

    // Scenario 5: reset mid-tile discards buffered and in-flight vectors.
    do_reset();
    step(1'b1, mk(32'h300), 1'b0);
    step(1'b1, mk(32'h301), 1'b0);
    idle(4, 1'b0);
    step(1'b1, mk(32'h302), 1'b0);
    idle(1, 1'b0);
    chk("s5_buffered", out_valid, 1);
    do_reset();
    idle(6, 1'b0);
    chk("s5_discarded", out_valid, 0);
    for (int i = 0; i < 3; i++) step(1'b1, mk(32'h310 + i), 1'b0);
    idle(5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1);
      chk("s5_head", out_data[31:0], 32'h310 + k);
      chk("s5_last", out_last, k == 2);
    end
    idle(1, 1'b0);
    chk("s5_empty", out_valid, 0);

    // Scenario 6: single column, no de-skew stages, one-cycle latency.
    d1_south = 32'hCAFE_0001;
    d1_valid = 1'b1;
    #1;
    chk("s6_not_yet", d1_ovalid, 0);
    idle(1, 1'b0);
    d1_valid = 1'b0;
    d1_south = '0;
    chk("s6_valid", d1_ovalid, 1);
    chk("s6_data", d1_data, 32'hCAFE_0001);
    chk("s6_last", d1_last, 0);
    d1_ready = 1'b1;
    idle(1, 1'b0);
    d1_ready = 1'b0;
    chk("s6_drained", d1_ovalid, 0);
    chk("s6_ovf", d1_ovf, 0);

    idle(2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
